// File: rtl/regfile_pkg.sv
// Shared defaults and typedefs for the parametrised register file with scoreboard.
package regfile_pkg;

  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_DEPTH  = 32;
  localparam int unsigned REG_NUM_RD = 2;
  localparam int unsigned REG_ADDR_W = $clog2(REG_DEPTH);

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Writeback / issue / read bus of the register file; master is the pipeline, slave the regfile.
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned DEPTH  = REG_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned NUM_RD = REG_NUM_RD
);

  logic                     ctrl_writeEnable;
  logic [ADDR_W-1:0]        ctrl_writeReg;
  logic [DATA_W-1:0]        data_writeReg;
  logic                     ctrl_issueEnable;
  logic [ADDR_W-1:0]        ctrl_issueReg;
  logic [NUM_RD*ADDR_W-1:0] ctrl_readReg;
  logic [NUM_RD*DATA_W-1:0] data_readReg;
  logic [NUM_RD-1:0]        busy_readReg;
  logic [ADDR_W:0]          busy_count;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_issueEnable, ctrl_issueReg, ctrl_readReg,
    input  data_readReg, busy_readReg, busy_count
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_issueEnable, ctrl_issueReg, ctrl_readReg,
    output data_readReg, busy_readReg, busy_count
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: index mux, r0 override and optional write bypass.
// Bypass is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned DEPTH  = REG_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] regData,
  input  logic [DEPTH-1:0]             busyBits,
  input  logic [ADDR_W-1:0]            rdIdx,
  input  logic                         wrEn,
  input  logic [ADDR_W-1:0]            wrIdx,
  input  logic [DATA_W-1:0]            wrData,
  input  logic                         isEn,
  input  logic [ADDR_W-1:0]            isIdx,
  output logic [DATA_W-1:0]            rdData_c,
  output logic                         rdBusy_c
);

  always_comb begin
    rdData_c = regData[rdIdx];
    rdBusy_c = busyBits[rdIdx];
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write; a same-cycle issue to this register keeps it busy.
    if (wrEn && (wrIdx == rdIdx)) begin
      rdData_c = wrData;
      rdBusy_c = isEn && (isIdx == rdIdx);
    end
`endif
    if (rdIdx == '0) begin
      rdData_c = '0;
      rdBusy_c = 1'b0;
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic unusedBypass;
  assign unusedBypass = ^{wrEn, wrIdx, wrData, isEn, isIdx};
`endif

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with per-register busy scoreboard and busy counter.
// Optional write-to-read bypass under REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned DEPTH  = REG_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned NUM_RD = REG_NUM_RD
) (
  input logic                  clock,
  input logic                  ctrl_reset_n,
  regfile_scoreboard_if.slave  rf
);

  logic [DEPTH-1:0][DATA_W-1:0] regData;
  logic [DEPTH-1:0]             busyBits;
  logic [ADDR_W:0]              busyCount;
  logic                         wrValid;
  logic                         isValid;
  logic                         setBusy;
  logic                         clrBusy;

  // Counter deltas: a same-register issue overrides the write's clear.
  always_comb begin
    wrValid = rf.ctrl_writeEnable && (rf.ctrl_writeReg != '0);
    isValid = rf.ctrl_issueEnable && (rf.ctrl_issueReg != '0);
    setBusy = isValid && !busyBits[rf.ctrl_issueReg];
    clrBusy = wrValid && busyBits[rf.ctrl_writeReg] &&
              !(isValid && (rf.ctrl_issueReg == rf.ctrl_writeReg));
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      regData   <= '0;
      busyBits  <= '0;
      busyCount <= '0;
    end else begin
      if (wrValid) begin
        regData[rf.ctrl_writeReg]  <= rf.data_writeReg;
        busyBits[rf.ctrl_writeReg] <= 1'b0;
      end
      if (isValid) begin
        busyBits[rf.ctrl_issueReg] <= 1'b1;
      end
      busyCount <= busyCount + (ADDR_W+1)'(setBusy) - (ADDR_W+1)'(clrBusy);
    end
  end

  assign rf.busy_count = busyCount;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH),
      .ADDR_W(ADDR_W)
    ) u_port (
      .regData (regData),
      .busyBits(busyBits),
      .rdIdx   (rf.ctrl_readReg[k*ADDR_W +: ADDR_W]),
      .wrEn    (wrValid),
      .wrIdx   (rf.ctrl_writeReg),
      .wrData  (rf.data_writeReg),
      .isEn    (isValid),
      .isIdx   (rf.ctrl_issueReg),
      .rdData_c(rf.data_readReg[k*DATA_W +: DATA_W]),
      .rdBusy_c(rf.busy_readReg[k])
    );
  end

endmodule
